// File: rtl/ls_queue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ls_queue_ctrl
// Purpose : In-order load/store queue. Issues ops to MemCtrl one at a time,
//           extends load data and broadcasts completions on the CDB.
// Rev     : 1.0
// ============================================================================
module ls_queue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int QDEPTH     = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  rdy_lsb_in,
    input  logic                  is_store_lsb_in,
    input  logic [2:0]            funct3_lsb_in,
    input  logic [DATA_WIDTH-1:0] vj_lsb_in,
    input  logic [DATA_WIDTH-1:0] vk_lsb_in,
    input  logic [DATA_WIDTH-1:0] imm_lsb_in,
    input  logic [ROB_WIDTH-1:0]  rob_id_lsb_in,
    output logic                  full_lsb_out,
    output logic                  req_mc_out,
    output logic                  wr_mc_out,
    output logic [ADDR_WIDTH-1:0] addr_mc_out,
    output logic [2:0]            len_mc_out,
    output logic [DATA_WIDTH-1:0] data_s_mc_out,
    input  logic [DATA_WIDTH-1:0] data_l_mc_in,
    input  logic                  done_mc_in,
    input  logic                  refresh_rob_cdb_in,
    output logic                  rdy_ls_cdb_out,
    output logic [DATA_WIDTH-1:0] result_ls_cdb_out,
    output logic [ROB_WIDTH-1:0]  rob_id_ls_cdb_out,
    output logic                  busy_out
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    logic [ADDR_WIDTH-1:0] addr_mem_q [QDEPTH];
    logic                  wr_mem_q   [QDEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [QDEPTH];
    logic [2:0]            f3_mem_q   [QDEPTH];
    logic [ROB_WIDTH-1:0]  tag_mem_q  [QDEPTH];

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic                  full_q, full_d;
    logic                  req_q, req_d, wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            len_q, len_d, f3_q, f3_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ROB_WIDTH-1:0]  tag_q, tag_d;
    logic                  cdb_vld_q, cdb_vld_d;
    logic [DATA_WIDTH-1:0] cdb_res_q, cdb_res_d;
    logic [ROB_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;

    logic                  w_push, w_pop;
    logic [SUM_W-1:0]      w_sum;

    function automatic logic [2:0] len_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   len_of = 3'd1;
            2'b01:   len_of = 3'd2;
            default: len_of = 3'd4;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [2:0] f3,
                                                     input logic [DATA_WIDTH-1:0] d);
        case (f3)
            3'b000:  extend = {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
            3'b001:  extend = {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
            3'b100:  extend = {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
            3'b101:  extend = {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    assign w_sum  = SUM_W'(vj_lsb_in) + SUM_W'(imm_lsb_in);
    assign w_push = rdy_lsb_in && !full_q && !refresh_rob_cdb_in;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        len_d     = len_q;
        data_d    = data_q;
        f3_d      = f3_q;
        tag_d     = tag_q;
        cdb_vld_d = 1'b0;
        cdb_res_d = cdb_res_q;
        cdb_tag_d = cdb_tag_q;
        w_pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!refresh_rob_cdb_in && count_q != '0) begin
                    w_pop   = 1'b1;
                    req_d   = 1'b1;
                    wr_d    = wr_mem_q[rd_ptr_q];
                    addr_d  = addr_mem_q[rd_ptr_q];
                    len_d   = len_of(f3_mem_q[rd_ptr_q]);
                    data_d  = data_mem_q[rd_ptr_q];
                    f3_d    = f3_mem_q[rd_ptr_q];
                    tag_d   = tag_mem_q[rd_ptr_q];
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_mc_in) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                    if (!refresh_rob_cdb_in) begin
                        cdb_vld_d = 1'b1;
                        cdb_tag_d = tag_q;
                        cdb_res_d = wr_q ? '0 : extend(f3_q, data_l_mc_in);
                    end
                end else if (refresh_rob_cdb_in) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Flushed access: finish the handshake but never broadcast it.
                if (done_mc_in) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (refresh_rob_cdb_in) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
            rd_ptr_d = rd_ptr_q + PTR_W'(w_pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(w_push);
        end
        full_d = (count_d == CNT_W'(QDEPTH));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            full_q    <= 1'b0;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            data_q    <= '0;
            f3_q      <= '0;
            tag_q     <= '0;
            cdb_vld_q <= 1'b0;
            cdb_res_q <= '0;
            cdb_tag_q <= '0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            full_q    <= full_d;
            req_q     <= req_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            data_q    <= data_d;
            f3_q      <= f3_d;
            tag_q     <= tag_d;
            cdb_vld_q <= cdb_vld_d;
            cdb_res_q <= cdb_res_d;
            cdb_tag_q <= cdb_tag_d;
        end
    end

    // Queue payload needs no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk_in) begin
        if (rst_n_in && rdy_in && w_push) begin
            addr_mem_q[wr_ptr_q] <= w_sum[ADDR_WIDTH-1:0];
            wr_mem_q[wr_ptr_q]   <= is_store_lsb_in;
            data_mem_q[wr_ptr_q] <= vk_lsb_in;
            f3_mem_q[wr_ptr_q]   <= funct3_lsb_in;
            tag_mem_q[wr_ptr_q]  <= rob_id_lsb_in;
        end
    end

    assign full_lsb_out      = full_q;
    assign req_mc_out        = req_q;
    assign wr_mc_out         = wr_q;
    assign addr_mc_out       = addr_q;
    assign len_mc_out        = len_q;
    assign data_s_mc_out     = data_q;
    assign rdy_ls_cdb_out    = cdb_vld_q;
    assign result_ls_cdb_out = cdb_res_q;
    assign rob_id_ls_cdb_out = cdb_tag_q;
    assign busy_out          = (count_q != '0) || (state_q != S_IDLE);

endmodule
`default_nettype wire
